jtag_tdr_bank: RTL and testbench
================================

Name: jtag_tdr_bank

Overview:
- Parametrised bank of NUM_TDR JTAG test data registers sharing one TDI/TDO path, plus a 1-bit bypass register.
- Sits behind the TAP controller and instruction decoder: takes Capture_DR/Shift_DR/Update_DR and a channel select, and drives TDO plus per-channel parallel outputs.
- Adds to the earlier single-register design:
  - multiple channels;
  - a bypass path;
  - a one-cycle update strobe;
  - a shift-length error check;
  - optional parallel capture.

Parameters:
- DR_Length, 5, bits per data register; must be >= 2.
- NUM_TDR, 4, number of data register channels; must be >= 1.
- SEL_W, 3, width of tdr_sel; must satisfy 2**SEL_W > NUM_TDR so bypass is addressable.
- UPD_RST, 0, reset value of every update (shadow) register, DR_Length bits.

Ports:
- TCK  input  1  test clock; all state changes on rising edge.
- TRST_N  input  1  asynchronous active-low reset.
- TDI  input  1  serial data in.
- Capture_DR  input  1  capture command from TAP controller.
- Shift_DR  input  1  shift command.
- Update_DR  input  1  update command.
- tdr_sel  input  SEL_W  values 0..NUM_TDR-1 select that channel; any other value selects bypass.
- DR_IN  input  NUM_TDR*DR_Length  parallel capture data, channel i at [i*DR_Length +: DR_Length]; used only with the optional feature.
- TDO  output  1  serial data out.
- DR_OUT  output  NUM_TDR*DR_Length  update register contents, same packing as DR_IN.
- upd_strobe  output  NUM_TDR  one-cycle pulse per channel after update.
- len_err  output  NUM_TDR  per-channel shift-length error flag.

Behaviour:
- Reset (TRST_N low, asynchronous, any time including mid-shift):
  - all shift registers, bypass register, shift counters, upd_strobe and len_err clear to 0;
  - update registers load UPD_RST;
  - TDO therefore reads 0.
- Only the selected channel (or bypass) reacts to commands. Deselected channels hold all state, including when tdr_sel changes mid-shift.
- Command priority per edge: Capture > Shift > Update. Lower-priority commands asserted in the same cycle are ignored.
- Capture on the selected channel:
  - shift register loads all-ones, or DR_IN slice with the feature;
  - shift counter loads 0;
  - len_err[i] clears.
- Shift on the selected channel:
  - shift register <= {sr[DR_Length-2:0], TDI};
  - counter increments, saturating at DR_Length+1.
- Update on the selected channel:
  - update register <= shift register;
  - upd_strobe[i] is high for exactly the following cycle;
  - len_err[i] <= (counter != DR_Length).
- Update on bypass or with no command: upd_strobe is all zeros next cycle.
- Bypass register: Capture loads 0; Shift loads TDI; Update has no effect.
- TDO is combinational:
  - selected channel: sr[DR_Length-1];
  - bypass selected: bypass register.
- Counter width: clog2(DR_Length+2).
- DR_OUT changes only on Update or reset. Shifting never disturbs DR_OUT.

Optional Feature:
- Macro: JTAG_TDR_PARALLEL_CAPTURE_EN.
- Defined: Capture loads the shift register from the channel's DR_IN slice.
- Undefined: Capture loads all-ones, DR_IN is unused, and the bank is drop-in compatible with the single-register behaviour.

Decomposition:
- Package jtag_tdr_pkg holds:
  - a count-width helper function;
  - a localparam for the bypass select default (all-ones select);
  - a typedef for the command priority enum (CMD_NONE, CMD_CAPTURE, CMD_SHIFT, CMD_UPDATE).
- One sub-module, jtag_tdr_cell, holds one channel's shift register, counter, update register, strobe and len_err, with an enable input.
- The bank instantiates NUM_TDR cells via generate and adds the bypass flop and TDO mux.

Test Plan:
- Reset: pulse TRST_N low mid-shift -> DR_OUT=0, TDO=0, upd_strobe=0, len_err=0 immediately, without waiting for TCK.
- tdr_sel=2, Capture, shift TDI 1,0,1,1,0, then Update:
  - TDO=1 throughout;
  - DR_OUT[14:10]=5'b10110;
  - upd_strobe=4'b0100 for one cycle;
  - len_err[2]=0;
  - other channels unchanged.
- tdr_sel=1, Capture, shift 3 bits, Update -> len_err[1]=1. A following Capture on channel 1 -> len_err[1]=0.
- tdr_sel=7 (bypass), Capture, shift TDI 1,0,1:
  - TDO=0 before the first shift, then 1,0,1 after each edge;
  - DR_OUT and upd_strobe never change.
- tdr_sel=0, Capture and Update asserted together -> capture occurs, DR_OUT unchanged, no upd_strobe.
- With JTAG_TDR_PARALLEL_CAPTURE_EN: DR_IN[4:0]=5'b01001, tdr_sel=0, Capture, shift 4 zeros -> TDO 0,1,0,0,1.

Source files
------------

// File: rtl/jtag_tdr_pkg.sv
// -----------------------------------------------------------------------------
// jtag_tdr_pkg
// Shared definitions for the JTAG test data register bank.
//   - tdr_cnt_w()      : width of a channel's shift-length counter
//   - TDR_SEL_BYPASS   : all-ones select pattern used to mean "bypass"
//   - tdr_cmd_e        : decoded TAP command after Capture > Shift > Update
//                        priority resolution
// -----------------------------------------------------------------------------
package jtag_tdr_pkg;

    // The counter must hold 0 .. dr_len+1 (one past full length marks overshift).
    function automatic int tdr_cnt_w(input int dr_len);
        return $clog2(dr_len + 2);
    endfunction

    // Wide all-ones pattern; the bank slices it down to its select width.
    localparam logic [31:0] TDR_SEL_BYPASS = '1;

    typedef enum logic [1:0] {
        CMD_NONE    = 2'd0,
        CMD_CAPTURE = 2'd1,
        CMD_SHIFT   = 2'd2,
        CMD_UPDATE  = 2'd3
    } tdr_cmd_e;

endpackage : jtag_tdr_pkg

// File: rtl/jtag_tdr_cell.sv
// -----------------------------------------------------------------------------
// jtag_tdr_cell
// One JTAG data register channel: shift register, shift-length counter,
// update (shadow) register, one-cycle update strobe and length-error flag.
// State only moves when en is high; the strobe self-clears every cycle.
//
// Ports:
//   TCK         in   test clock, rising edge
//   TRST_N      in   asynchronous active-low reset
//   en          in   this channel is the selected one
//   cmd         in   priority-resolved command
//   tdi         in   serial data in
//   cap_data    in   value loaded into the shift register on capture
//   so          out  serial out (shift register MSB)
//   dr_out      out  update register contents
//   upd_strobe  out  high for the cycle after an update on this channel
//   len_err     out  last update saw a shift count other than DR_Length
// -----------------------------------------------------------------------------
module jtag_tdr_cell
    import jtag_tdr_pkg::*;
#(
    parameter int                   DR_Length = 5,
    parameter logic [DR_Length-1:0] UPD_RST   = '0
) (
    input  logic                 TCK,
    input  logic                 TRST_N,
    input  logic                 en,
    input  tdr_cmd_e             cmd,
    input  logic                 tdi,
    input  logic [DR_Length-1:0] cap_data,
    output logic                 so,
    output logic [DR_Length-1:0] dr_out,
    output logic                 upd_strobe,
    output logic                 len_err
);

    localparam int               CNT_W    = tdr_cnt_w(DR_Length);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_Length);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DR_Length + 1);

    // Saturating increment: once past full length the exact overshoot is irrelevant.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
    endfunction

    logic [DR_Length-1:0] sr;
    logic [CNT_W-1:0]     cnt;

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            sr         <= '0;
            cnt        <= '0;
            dr_out     <= UPD_RST;
            upd_strobe <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            upd_strobe <= 1'b0;
            if (en) begin
                case (cmd)
                    CMD_CAPTURE: begin
                        sr      <= cap_data;
                        cnt     <= '0;
                        len_err <= 1'b0;
                    end
                    CMD_SHIFT: begin
                        sr  <= {sr[DR_Length-2:0], tdi};
                        cnt <= sat_inc(cnt);
                    end
                    CMD_UPDATE: begin
                        dr_out     <= sr;
                        upd_strobe <= 1'b1;
                        len_err    <= (cnt != CNT_FULL);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign so = sr[DR_Length-1];

endmodule : jtag_tdr_cell

// File: rtl/jtag_tdr_bank.sv
// -----------------------------------------------------------------------------
// jtag_tdr_bank
// NUM_TDR JTAG test data registers sharing one TDI/TDO path, plus a 1-bit
// bypass register. tdr_sel values 0..NUM_TDR-1 pick a channel, anything else
// picks bypass. Command priority is Capture > Shift > Update.
//
// Build option:
//   JTAG_TDR_PARALLEL_CAPTURE_EN  defined   : capture loads the channel's DR_IN slice
//                                 undefined : capture loads all-ones, DR_IN unused
//
// Ports:
//   TCK, TRST_N     test clock / asynchronous active-low reset
//   TDI, TDO        serial in / combinational serial out
//   Capture_DR, Shift_DR, Update_DR   TAP commands
//   tdr_sel         channel select (SEL_W bits)
//   DR_IN           parallel capture data, channel i at [i*DR_Length +: DR_Length]
//   DR_OUT          update register contents, same packing
//   upd_strobe      per-channel one-cycle pulse after update
//   len_err         per-channel shift-length error flag
// -----------------------------------------------------------------------------
module jtag_tdr_bank
    import jtag_tdr_pkg::*;
#(
    parameter int                   DR_Length = 5,
    parameter int                   NUM_TDR   = 4,
    parameter int                   SEL_W     = 3,
    parameter logic [DR_Length-1:0] UPD_RST   = '0
) (
    input  logic                           TCK,
    input  logic                           TRST_N,
    input  logic                           TDI,
    input  logic                           Capture_DR,
    input  logic                           Shift_DR,
    input  logic                           Update_DR,
    input  logic [SEL_W-1:0]               tdr_sel,
    input  logic [NUM_TDR*DR_Length-1:0]   DR_IN,
    output logic                           TDO,
    output logic [NUM_TDR*DR_Length-1:0]   DR_OUT,
    output logic [NUM_TDR-1:0]             upd_strobe,
    output logic [NUM_TDR-1:0]             len_err
);

    generate
        if (DR_Length < 2)
            $error("jtag_tdr_bank: DR_Length must be >= 2");
        if (NUM_TDR < 1)
            $error("jtag_tdr_bank: NUM_TDR must be >= 1");
        if ((2 ** SEL_W) <= NUM_TDR)
            $error("jtag_tdr_bank: SEL_W too small to address bypass");
    endgenerate

    localparam logic [SEL_W-1:0] SEL_BYP = TDR_SEL_BYPASS[SEL_W-1:0];

    tdr_cmd_e           cmd;
    logic [SEL_W-1:0]   sel_norm;
    logic               byp_sel;
    logic [NUM_TDR-1:0] chan_en;
    logic [NUM_TDR-1:0] chan_so;
    logic               byp_q;

    always_comb begin
        cmd = CMD_NONE;
        if (Capture_DR)
            cmd = CMD_CAPTURE;
        else if (Shift_DR)
            cmd = CMD_SHIFT;
        else if (Update_DR)
            cmd = CMD_UPDATE;
    end

    // Every out-of-range select folds onto the all-ones pattern, which can
    // never be a channel index because 2**SEL_W > NUM_TDR.
    always_comb begin
        sel_norm = SEL_BYP;
        if (32'(tdr_sel) < NUM_TDR)
            sel_norm = tdr_sel;
    end

    assign byp_sel = (sel_norm == SEL_BYP);

    genvar g;
    generate
        for (g = 0; g < NUM_TDR; g++) begin : g_cell
            logic [DR_Length-1:0] cap_data;

`ifdef JTAG_TDR_PARALLEL_CAPTURE_EN
            assign cap_data = DR_IN[g*DR_Length +: DR_Length];
`else
            assign cap_data = '1;
`endif

            assign chan_en[g] = (sel_norm == SEL_W'(g));

            jtag_tdr_cell #(
                .DR_Length (DR_Length),
                .UPD_RST   (UPD_RST)
            ) u_cell (
                .TCK        (TCK),
                .TRST_N     (TRST_N),
                .en         (chan_en[g]),
                .cmd        (cmd),
                .tdi        (TDI),
                .cap_data   (cap_data),
                .so         (chan_so[g]),
                .dr_out     (DR_OUT[g*DR_Length +: DR_Length]),
                .upd_strobe (upd_strobe[g]),
                .len_err    (len_err[g])
            );
        end
    endgenerate

`ifndef JTAG_TDR_PARALLEL_CAPTURE_EN
    // Parallel data is intentionally ignored in the all-ones capture build.
    logic dr_in_unused;
    assign dr_in_unused = ^DR_IN;
`endif

    // Bypass: capture clears, shift samples TDI, update is a no-op.
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            byp_q <= 1'b0;
        end else if (byp_sel) begin
            if (cmd == CMD_CAPTURE)
                byp_q <= 1'b0;
            else if (cmd == CMD_SHIFT)
                byp_q <= TDI;
        end
    end

    always_comb begin
        TDO = byp_q;
        for (int i = 0; i < NUM_TDR; i++) begin
            if (sel_norm == SEL_W'(i))
                TDO = chan_so[i];
        end
    end

endmodule : jtag_tdr_bank

// File: tb/tb_jtag_tdr_bank.sv
// -----------------------------------------------------------------------------
// tb_jtag_tdr_bank
// Directed scenarios plus randomized command streams against a behavioural
// model of the bank (per-channel integer state, rules applied per clock edge).
// -----------------------------------------------------------------------------
module tb_jtag_tdr_bank;

    localparam int L  = 5;
    localparam int N  = 4;
    localparam int SW = 3;
    localparam logic [L-1:0] MASK = '1;

    logic            TCK = 1'b0;
    logic            TRST_N = 1'b0;
    logic            TDI = 1'b0;
    logic            Capture_DR = 1'b0;
    logic            Shift_DR = 1'b0;
    logic            Update_DR = 1'b0;
    logic [SW-1:0]   tdr_sel = '0;
    logic [N*L-1:0]  DR_IN = '0;
    logic            TDO;
    logic [N*L-1:0]  DR_OUT;
    logic [N-1:0]    upd_strobe;
    logic [N-1:0]    len_err;

    jtag_tdr_bank #(
        .DR_Length (L),
        .NUM_TDR   (N),
        .SEL_W     (SW),
        .UPD_RST   ('0)
    ) dut (
        .TCK        (TCK),
        .TRST_N     (TRST_N),
        .TDI        (TDI),
        .Capture_DR (Capture_DR),
        .Shift_DR   (Shift_DR),
        .Update_DR  (Update_DR),
        .tdr_sel    (tdr_sel),
        .DR_IN      (DR_IN),
        .TDO        (TDO),
        .DR_OUT     (DR_OUT),
        .upd_strobe (upd_strobe),
        .len_err    (len_err)
    );

    always #5 TCK = ~TCK;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned m_sr  [N];
    int unsigned m_upd [N];
    int          m_cnt [N];
    bit          m_stb [N];
    bit          m_err [N];
    bit          m_byp;
    int          cur_sel;
    logic [N*L-1:0] din_next = '0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sr[i] = 0; m_upd[i] = 0; m_cnt[i] = 0; m_stb[i] = 0; m_err[i] = 0;
        end
        m_byp = 0;
    endtask

    task automatic model_edge(input bit cap, input bit sh, input bit up, input int sel,
                              input bit tdi, input logic [N*L-1:0] din);
        for (int i = 0; i < N; i++) m_stb[i] = 0;
        if (sel < N) begin
            if (cap) begin
`ifdef JTAG_TDR_PARALLEL_CAPTURE_EN
                m_sr[sel] = int'((din >> (sel * L)) & (N*L)'(MASK));
`else
                m_sr[sel] = (1 << L) - 1;
`endif
                m_cnt[sel] = 0;
                m_err[sel] = 0;
            end else if (sh) begin
                m_sr[sel]  = (m_sr[sel] * 2 + tdi) % (1 << L);
                m_cnt[sel] = (m_cnt[sel] + 1 > L + 1) ? L + 1 : m_cnt[sel] + 1;
            end else if (up) begin
                m_upd[sel] = m_sr[sel];
                m_stb[sel] = 1;
                m_err[sel] = (m_cnt[sel] != L);
            end
        end else begin
            if (cap) m_byp = 0;
            else if (sh) m_byp = tdi;
        end
    endtask

    function automatic logic exp_tdo();
        if (cur_sel < N) return logic'((m_sr[cur_sel] >> (L - 1)) & 1);
        return m_byp;
    endfunction

    function automatic logic [N*L-1:0] exp_dr();
        logic [N*L-1:0] v = '0;
        for (int i = N - 1; i >= 0; i--) v = (v << L) | (N*L)'(m_upd[i]);
        return v;
    endfunction

    function automatic logic [N-1:0] exp_vec(input bit stb);
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = stb ? m_stb[i] : m_err[i];
        return v;
    endfunction

    task automatic check_all();
        chk("tdo",    32'(TDO),        32'(exp_tdo()));
        chk("dr_out", 32'(DR_OUT),     32'(exp_dr()));
        chk("strobe", 32'(upd_strobe), 32'(exp_vec(1)));
        chk("len_err",32'(len_err),    32'(exp_vec(0)));
    endtask

    // One TCK cycle: drive at negedge, check TDO before the edge, step the
    // model on the rising edge and check every output just after it.
    task automatic cyc(input bit cap, input bit sh, input bit up, input int sel, input bit tdi);
        @(negedge TCK);
        Capture_DR = cap; Shift_DR = sh; Update_DR = up;
        tdr_sel = SW'(sel); TDI = tdi; DR_IN = din_next;
        cur_sel = sel;
        #1 chk("tdo_pre", 32'(TDO), 32'(exp_tdo()));
        @(posedge TCK);
        model_edge(cap, sh, up, sel, tdi, din_next);
        #1 check_all();
    endtask

    task automatic async_reset();
        @(negedge TCK);
        #2 TRST_N = 1'b0;
        #1;
        model_reset();
        chk("rst_tdo",    32'(TDO),        0);
        chk("rst_dr",     32'(DR_OUT),     0);
        chk("rst_strobe", 32'(upd_strobe), 0);
        chk("rst_lenerr", 32'(len_err),    0);
        @(negedge TCK);
        TRST_N = 1'b1;
    endtask

    initial begin
        bit bits5 [5] = '{1, 0, 1, 1, 0};
        bit bits3 [3] = '{1, 0, 1};
        cur_sel = 0;
        model_reset();

        // Power-on reset state
        #3;
        chk("por_tdo",    32'(TDO),        0);
        chk("por_dr",     32'(DR_OUT),     0);
        chk("por_strobe", 32'(upd_strobe), 0);
        chk("por_lenerr", 32'(len_err),    0);
        @(negedge TCK);
        TRST_N = 1'b1;

        // Channel 2: capture, shift 1,0,1,1,0, update
        cyc(1, 0, 0, 2, 0);
`ifndef JTAG_TDR_PARALLEL_CAPTURE_EN
        chk("ch2_tdo_cap", 32'(TDO), 1);
`endif
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 0, 2, bits5[k]);
`ifndef JTAG_TDR_PARALLEL_CAPTURE_EN
            chk("ch2_tdo_shift", 32'(TDO), 1);
`endif
        end
        chk("ch2_dr_hold", 32'(DR_OUT), 0);
        cyc(0, 0, 1, 2, 0);
        chk("ch2_dr", 32'(DR_OUT[14:10]), 32'(5'b10110));
        chk("ch2_others", 32'(DR_OUT[9:0]), 0);
        chk("ch2_strobe", 32'(upd_strobe), 32'(4'b0100));
        chk("ch2_lenerr", 32'(len_err[2]), 0);
        cyc(0, 0, 0, 2, 0);
        chk("ch2_strobe_off", 32'(upd_strobe), 0);

        // Channel 1: short shift -> length error, cleared by capture
        cyc(1, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 1, bits3[k]);
        cyc(0, 0, 1, 1, 0);
        chk("ch1_lenerr_set", 32'(len_err[1]), 1);
        cyc(1, 0, 0, 1, 0);
        chk("ch1_lenerr_clr", 32'(len_err[1]), 0);

        // Bypass
        cyc(1, 0, 0, 7, 1);
        chk("byp_cap", 32'(TDO), 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 7, bits3[k]);
            chk("byp_shift", 32'(TDO), 32'(bits3[k]));
        end
        cyc(0, 0, 1, 7, 0);
        chk("byp_strobe", 32'(upd_strobe), 0);

        // Channel 0: capture and update together -> capture wins
        cyc(1, 0, 1, 0, 0);
        chk("cap_upd_strobe", 32'(upd_strobe), 0);
        chk("cap_upd_dr0", 32'(DR_OUT[4:0]), 0);

`ifdef JTAG_TDR_PARALLEL_CAPTURE_EN
        begin
            bit tdo_seq [5] = '{0, 1, 0, 0, 1};
            din_next = '0;
            din_next[4:0] = 5'b01001;
            cyc(1, 0, 0, 0, 0);
            chk("par_tdo", 32'(TDO), 32'(tdo_seq[0]));
            for (int k = 1; k < 5; k++) begin
                cyc(0, 1, 0, 0, 0);
                chk("par_tdo", 32'(TDO), 32'(tdo_seq[k]));
            end
        end
`endif

        // Reset in the middle of a shift on channel 3
        cyc(1, 0, 0, 3, 0);
        cyc(0, 1, 0, 3, 1);
        cyc(0, 1, 0, 3, 0);
        async_reset();

        // Randomized command streams
        for (int n = 0; n < 600; n++) begin
            bit cap, sh, up;
            cap = ($urandom_range(0, 99) < 12);
            sh  = ($urandom_range(0, 99) < 60);
            up  = ($urandom_range(0, 99) < 18);
            din_next = (N*L)'({$urandom, $urandom});
            // Sticky select with occasional switches so channels get full shifts.
            if ($urandom_range(0, 99) < 15) cur_sel = $urandom_range(0, (1 << SW) - 1);
            cyc(cap, sh, up, cur_sel, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_jtag_tdr_bank
